comp1_cell: RTL and testbench

- Cascadable magnitude-comparator slice with an enable input.
- Compares operand a against operand b and reports greater, less and equal.
- The equal output acts as the enable for the next slice in a chain; an enclosing multi-bit comparator ORs the greater/less outputs across slices.
- Outputs are registered on one clock with an asynchronous, active-high reset.

---
 rtl/comp1_cell.sv | 50 +++++
 tb/tb_comp1_cell.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/comp1_cell.sv
// Cascadable unsigned magnitude-comparator slice: x = a>b, y = a<b, z = a==b, all gated by e.
// REG_OUT=1 gives 1-cycle latency, REG_OUT=0 is combinational; no backpressure, accepts every cycle.
module comp1_cell #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             x,
  output logic             y,
  output logic             z,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             e
);

  logic x_n;
  logic y_n;
  logic z_n;

  always_comb begin
    x_n = e & (a > b);
    y_n = e & (a < b);
    z_n = e & (a == b);
  end

  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          x <= 1'b0;
          y <= 1'b0;
          z <= 1'b0;
        end else begin
          x <= x_n;
          y <= y_n;
          z <= z_n;
        end
      end
    end else begin : g_comb
      // Reset still masks the flags so a chain reads all-zero while held in reset.
      always_comb begin
        x = x_n & ~rst;
        y = y_n & ~rst;
        z = z_n & ~rst;
      end
    end
  endgenerate

endmodule

// File: tb/tb_comp1_cell.sv
// Directed and random checks of comp1_cell in registered (1-bit, 8-bit) and combinational (4-bit) forms.
module tb_comp1_cell;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a1, b1, e1;
  logic       x1, y1, z1;
  logic [3:0] a4, b4;
  logic       e4;
  logic       x4, y4, z4;
  logic [7:0] a8, b8;
  logic       e8;
  logic       x8, y8, z8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  comp1_cell #(.WIDTH(1), .REG_OUT(1'b1)) u1 (
    .clk(clk), .rst(rst), .x(x1), .y(y1), .z(z1), .a(a1), .b(b1), .e(e1)
  );

  comp1_cell #(.WIDTH(4), .REG_OUT(1'b0)) u4 (
    .clk(clk), .rst(rst), .x(x4), .y(y4), .z(z4), .a(a4), .b(b4), .e(e4)
  );

  comp1_cell #(.WIDTH(8), .REG_OUT(1'b1)) u8 (
    .clk(clk), .rst(rst), .x(x8), .y(y8), .z(z8), .a(a8), .b(b8), .e(e8)
  );

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed xyz=%b expected xyz=%b", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] model8(input logic [7:0] a, input logic [7:0] b, input logic e);
    logic [2:0] r;
    r = 3'b000;
    if (e) begin
      if (a > b)      r = 3'b100;
      else if (a < b) r = 3'b010;
      else            r = 3'b001;
    end
    return r;
  endfunction

  logic [1:0] ab_vec [4];
  logic [2:0] exp_vec [4];
  logic [2:0] exp_q;

  initial begin
    ab_vec[0] = 2'b00; exp_vec[0] = 3'b001;
    ab_vec[1] = 2'b01; exp_vec[1] = 3'b010;
    ab_vec[2] = 2'b10; exp_vec[2] = 3'b100;
    ab_vec[3] = 2'b11; exp_vec[3] = 3'b001;

    a1 = 1'b1; b1 = 1'b0; e1 = 1'b1;
    a4 = 4'd0; b4 = 4'd0; e4 = 1'b0;
    a8 = 8'd0; b8 = 8'd0; e8 = 1'b0;

    // Reset held with a clock running: outputs pinned to zero.
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_hold", {x1, y1, z1}, 3'b000);
    end
    check("reset_u8", {x8, y8, z8}, 3'b000);
    rst = 1'b0;
    #2;
    check("post_release_pre_edge", {x1, y1, z1}, 3'b000);
    step();
    check("first_edge_after_reset", {x1, y1, z1}, 3'b100);

    // Exhaustive 1-bit, e=1, then e=0.
    for (int i = 0; i < 4; i++) begin
      a1 = ab_vec[i][1]; b1 = ab_vec[i][0]; e1 = 1'b1;
      step();
      check("exhaustive_e1", {x1, y1, z1}, exp_vec[i]);
    end
    for (int i = 0; i < 4; i++) begin
      a1 = ab_vec[i][1]; b1 = ab_vec[i][0]; e1 = 1'b0;
      step();
      check("enable_low", {x1, y1, z1}, 3'b000);
    end

    // Inputs changing between edges must not disturb registered outputs.
    a1 = 1'b0; b1 = 1'b1; e1 = 1'b1;
    step();
    check("less_registered", {x1, y1, z1}, 3'b010);
    a1 = 1'b1; b1 = 1'b0;
    #2;
    check("between_edges_stable", {x1, y1, z1}, 3'b010);
    a1 = 1'b0; b1 = 1'b1;

    // Asynchronous reset pulse between edges.
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_immediate", {x1, y1, z1}, 3'b000);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_released_no_edge", {x1, y1, z1}, 3'b000);
    step();
    check("async_reset_recover", {x1, y1, z1}, 3'b010);

    // Combinational 4-bit instance, no clock edge between set and check.
    @(negedge clk);
    a4 = 4'b1010; b4 = 4'b0110; e4 = 1'b1;
    #1;
    check("comb_greater", {x4, y4, z4}, 3'b100);
    a4 = 4'b1111; b4 = 4'b1111;
    #1;
    check("comb_equal", {x4, y4, z4}, 3'b001);
    a4 = 4'b0011; b4 = 4'b1000;
    #1;
    check("comb_less", {x4, y4, z4}, 3'b010);
    e4 = 1'b0;
    #1;
    check("comb_enable_low", {x4, y4, z4}, 3'b000);
    e4 = 1'b1;
    rst = 1'b1;
    #1;
    check("comb_reset_forces_zero", {x4, y4, z4}, 3'b000);
    rst = 1'b0;
    #1;
    check("comb_after_reset", {x4, y4, z4}, 3'b010);

    // 8-bit boundaries.
    a8 = 8'hFF; b8 = 8'h00; e8 = 1'b1;
    step();
    check("w8_allones_vs_zero", {x8, y8, z8}, 3'b100);
    a8 = 8'h00; b8 = 8'hFF;
    step();
    check("w8_zero_vs_allones", {x8, y8, z8}, 3'b010);
    a8 = 8'h00; b8 = 8'h00;
    step();
    check("w8_zero_equal", {x8, y8, z8}, 3'b001);
    a8 = 8'h80; b8 = 8'h7F;
    step();
    check("w8_msb_unsigned", {x8, y8, z8}, 3'b100);

    // Enable toggling every cycle.
    a8 = 8'd5; b8 = 8'd3;
    for (int i = 0; i < 6; i++) begin
      e8 = (i % 2 == 0);
      step();
      check("enable_toggle", {x8, y8, z8}, (i % 2 == 0) ? 3'b100 : 3'b000);
    end

    // Random soak against the reference model of the previous cycle's inputs.
    for (int i = 0; i < 300; i++) begin
      a8 = 8'($urandom_range(0, 255));
      b8 = (i % 5 == 0) ? a8 : 8'($urandom_range(0, 255));
      e8 = 1'($urandom_range(0, 1));
      exp_q = model8(a8, b8, e8);
      step();
      check("soak", {x8, y8, z8}, exp_q);
      if (e8) begin
        checks++;
        assert ($onehot({x8, y8, z8})) else begin
          failures++;
          $error("FAIL soak_onehot observed xyz=%b expected one-hot", {x8, y8, z8});
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
